// File: rtl/csdf_1p_2f_split.sv
// Tag-based splitter: pops tagged tokens from one FWFT FIFO and routes the payload
// to one of two per-flow output FIFOs through a single skid entry per flow.
module csdf_1p_2f_split #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 empty,
    output logic                 rd,
    input  logic                 full0,
    input  logic                 full1,
    output logic                 wr0,
    output logic                 wr1,
    output logic [WIDTH-2:0]     out0_data,
    output logic [WIDTH-2:0]     out1_data,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-2:0] hold0, hold1;
    logic             v0, v1;
    logic             free0, free1;
    logic             tag;
    logic [WIDTH-2:0] payload;
    logic             take0, take1;

    assign tag     = in_data[WIDTH-1];
    assign payload = in_data[WIDTH-2:0];

    assign wr0       = v0 & ~full0;
    assign wr1       = v1 & ~full1;
    assign out0_data = hold0;
    assign out1_data = hold1;

    // A slot counts as free when it is empty or is being written out this cycle.
    assign free0 = ~v0 | wr0;
    assign free1 = ~v1 | wr1;

    // Strict in-order consumption: a blocked head token stalls both flows.
    assign rd    = ~rst & ~empty & (tag ? free1 : free0);
    assign take0 = rd & ~tag;
    assign take1 = rd & tag;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold0 <= '0;
            v0    <= 1'b0;
            cnt0  <= '0;
        end else begin
            if (take0) begin
                hold0 <= payload;
                v0    <= 1'b1;
            end else if (wr0) begin
                v0 <= 1'b0;
            end
            if (wr0) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold1 <= '0;
            v1    <= 1'b0;
            cnt1  <= '0;
        end else begin
            if (take1) begin
                hold1 <= payload;
                v1    <= 1'b1;
            end else if (wr1) begin
                v1 <= 1'b0;
            end
            if (wr1) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

endmodule
